// File: rtl/aw_seq_tagger.sv
// aw_seq_tagger
//   Initiator-side write-address tagger for a single master ID. Each accepted
//   AW request is stamped with {seq, ID} and held in a one-entry registered
//   slice. The block watches the B channel and retires tagged transactions
//   strictly in allocation order. An out-of-order or unexpected response for
//   this ID produces a one-cycle seq_err pulse.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   s_awvalid/s_awready  upstream AW handshake
//   s_awpayload          opaque upstream AW payload
//   m_awvalid/m_awready  downstream AW handshake (registered valid)
//   m_awid               {seq, ID} tag of the request in the slice
//   m_awpayload          registered payload
//   bid/bvalid/bready    monitored write-response channel
//   outstanding          allocated, unretired transaction count
//   full, empty          outstanding == MAX_OUT / outstanding == 0
//   seq_err              registered one-cycle response violation pulse
module aw_seq_tagger #(
    parameter int unsigned         ID_width      = 2,
    parameter logic [ID_width-1:0] ID            = '0,
    parameter int unsigned         seq_width     = 4,
    parameter int unsigned         MAX_OUT       = 8,
    parameter int unsigned         PAYLOAD_width = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_awvalid,
    output logic                          s_awready,
    input  logic [PAYLOAD_width-1:0]      s_awpayload,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [ID_width+seq_width-1:0] m_awid,
    output logic [PAYLOAD_width-1:0]      m_awpayload,
    input  logic [ID_width+seq_width-1:0] bid,
    input  logic                          bvalid,
    input  logic                          bready,
    output logic [seq_width:0]            outstanding,
    output logic                          full,
    output logic                          empty,
    output logic                          seq_err
);

    localparam logic [seq_width:0]   LP_MAX_OUT = (seq_width+1)'(MAX_OUT);
    localparam logic [seq_width:0]   LP_CNT_ONE = (seq_width+1)'(1);
    localparam logic [seq_width-1:0] LP_SEQ_ONE = seq_width'(1);

    logic                          r_awvalid;
    logic [ID_width+seq_width-1:0] r_awid;
    logic [PAYLOAD_width-1:0]      r_awpayload;
    logic [seq_width-1:0]          r_next_seq;
    logic [seq_width-1:0]          r_oldest_seq;
    logic [seq_width:0]            r_outstanding;
    logic                          r_seq_err;

    logic                          w_full;
    logic                          w_empty;
    logic                          w_awready;
    logic                          w_accept;
    logic                          w_id_hit;
    logic [seq_width-1:0]          w_bseq;
    logic                          w_retire;
    logic                          w_err;

    assign w_full    = (r_outstanding == LP_MAX_OUT);
    assign w_empty   = (r_outstanding == '0);

    // Ready ignores s_awvalid; a retire in the same cycle does not reopen a full window.
    assign w_awready = (!r_awvalid || m_awready) && !w_full;
    assign w_accept  = s_awvalid && w_awready;

    assign w_id_hit  = bvalid && bready && (bid[ID_width-1:0] == ID);
    assign w_bseq    = bid[ID_width+seq_width-1:ID_width];
    assign w_retire  = w_id_hit && !w_empty && (w_bseq == r_oldest_seq);
    assign w_err     = w_id_hit && (w_empty || (w_bseq != r_oldest_seq));

    // Output slice: load on accept, drop valid only on a drain without a refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_awvalid   <= 1'b0;
            r_awid      <= '0;
            r_awpayload <= '0;
        end else if (w_accept) begin
            r_awvalid   <= 1'b1;
            r_awid      <= {r_next_seq, ID};
            r_awpayload <= s_awpayload;
        end else if (r_awvalid && m_awready) begin
            r_awvalid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_next_seq    <= '0;
            r_oldest_seq  <= '0;
            r_outstanding <= '0;
            r_seq_err     <= 1'b0;
        end else begin
            r_seq_err <= w_err;
            if (w_accept) begin
                r_next_seq <= r_next_seq + LP_SEQ_ONE;
            end
            if (w_retire) begin
                r_oldest_seq <= r_oldest_seq + LP_SEQ_ONE;
            end
            unique case ({w_accept, w_retire})
                2'b10:   r_outstanding <= r_outstanding + LP_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - LP_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign s_awready   = w_awready;
    assign m_awvalid   = r_awvalid;
    assign m_awid      = r_awid;
    assign m_awpayload = r_awpayload;
    assign outstanding = r_outstanding;
    assign full        = w_full;
    assign empty       = w_empty;
    assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_aw_seq_tagger.sv
module tb_aw_seq_tagger;

    localparam logic [1:0] ID1 = 2'b00;
    localparam logic [1:0] ID2 = 2'b01;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: default parameters
    logic        reset, s_awvalid, s_awready, m_awvalid, m_awready;
    logic [63:0] s_awpayload, m_awpayload;
    logic [5:0]  m_awid, bid;
    logic        bvalid, bready, full, empty, seq_err;
    logic [4:0]  outstanding;

    aw_seq_tagger #(.ID_width(2), .ID(ID1), .seq_width(4), .MAX_OUT(8), .PAYLOAD_width(64)) u_dut (
        .clk(clk), .reset(reset),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awpayload(s_awpayload),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awpayload(m_awpayload),
        .bid(bid), .bvalid(bvalid), .bready(bready),
        .outstanding(outstanding), .full(full), .empty(empty), .seq_err(seq_err)
    );

    // small instance for sequence wrap-around
    logic        d2_reset, d2_s_awvalid, d2_s_awready, d2_m_awvalid, d2_m_awready;
    logic [7:0]  d2_s_awpayload, d2_m_awpayload;
    logic [3:0]  d2_m_awid, d2_bid;
    logic        d2_bvalid, d2_bready, d2_full, d2_empty, d2_seq_err;
    logic [2:0]  d2_outstanding;

    aw_seq_tagger #(.ID_width(2), .ID(ID2), .seq_width(2), .MAX_OUT(4), .PAYLOAD_width(8)) u_dut2 (
        .clk(clk), .reset(d2_reset),
        .s_awvalid(d2_s_awvalid), .s_awready(d2_s_awready), .s_awpayload(d2_s_awpayload),
        .m_awvalid(d2_m_awvalid), .m_awready(d2_m_awready), .m_awid(d2_m_awid), .m_awpayload(d2_m_awpayload),
        .bid(d2_bid), .bvalid(d2_bvalid), .bready(d2_bready),
        .outstanding(d2_outstanding), .full(d2_full), .empty(d2_empty), .seq_err(d2_seq_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: live tags in allocation order plus a total accept count.
    bit          mdl_ok = 0;
    bit          mdl_valid;
    logic [5:0]  mdl_id;
    logic [63:0] mdl_pl;
    bit          mdl_err;
    int unsigned mdl_alloc;
    int          live[$];

    task automatic step(input bit rst, input bit av, input logic [63:0] pl,
                        input bit mr, input bit bv, input bit br, input logic [5:0] b);
        bit rdy, acc, hit;
        int bseq;
        @(negedge clk);
        reset = rst; s_awvalid = av; s_awpayload = pl;
        m_awready = mr; bvalid = bv; bready = br; bid = b;
        #1;
        rdy = (!mdl_valid || mr) && (live.size() < 8);
        if (mdl_ok) begin
            check("s_awready",   s_awready,   rdy);
            check("m_awvalid",   m_awvalid,   mdl_valid);
            check("m_awid",      m_awid,      mdl_id);
            check("m_awpayload", m_awpayload, mdl_pl);
            check("outstanding", outstanding, live.size());
            check("full",        full,        live.size() == 8);
            check("empty",       empty,       live.size() == 0);
            check("seq_err",     seq_err,     mdl_err);
        end
        if (rst) begin
            mdl_valid = 0; mdl_id = '0; mdl_pl = '0; mdl_err = 0;
            mdl_alloc = 0; live.delete(); mdl_ok = 1;
        end else begin
            acc  = av && rdy;
            hit  = bv && br && (b[1:0] == ID1);
            bseq = int'(b[5:2]);
            mdl_err = hit && (live.size() == 0 || bseq != live[0]);
            if (hit && !mdl_err) void'(live.pop_front());
            if (acc) begin
                mdl_valid = 1;
                mdl_pl    = pl;
                mdl_id    = {4'(mdl_alloc % 16), ID1};
                live.push_back(int'(mdl_alloc % 16));
                mdl_alloc++;
            end else if (mdl_valid && mr) begin
                mdl_valid = 0;
            end
        end
    endtask

    task automatic idle(input bit mr);
        step(0, 0, 64'h0, mr, 0, 0, 6'h0);
    endtask

    task automatic resp(input logic [3:0] s, input logic [1:0] id);
        step(0, 0, 64'h0, 1, 1, 1, {s, id});
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 64'h0, 1, 0, 0, 6'h0);
    endtask

    initial begin
        reset = 1; s_awvalid = 0; s_awpayload = '0; m_awready = 1;
        bvalid = 0; bready = 0; bid = '0;
        d2_reset = 1; d2_s_awvalid = 0; d2_s_awpayload = '0; d2_m_awready = 1;
        d2_bvalid = 0; d2_bready = 0; d2_bid = '0;

        // reset and a single transaction
        do_reset(2);
        idle(1);
        step(0, 1, 64'h1234, 1, 0, 0, 6'h0);
        idle(1);
        resp(4'h0, ID1);
        idle(1);
        idle(1);

        // fill the window, overflow attempt, then free a slot
        for (int i = 0; i < 10; i++) step(0, 1, 64'(100 + i), 1, 0, 0, 6'h0);
        step(0, 1, 64'd200, 1, 1, 1, {4'h1, ID1});
        step(0, 1, 64'd201, 1, 0, 0, 6'h0);
        idle(1);

        // backpressure then release
        do_reset(1);
        for (int i = 0; i < 5; i++) step(0, 1, 64'(300 + i), 0, 0, 0, 6'h0);
        for (int i = 0; i < 4; i++) step(0, 1, 64'(400 + i), 1, 0, 0, 6'h0);
        idle(1);

        // protocol errors and foreign IDs
        do_reset(1);
        step(0, 1, 64'hA, 1, 0, 0, 6'h0);
        resp(4'h3, ID1);
        resp(4'h0, 2'b10);
        step(0, 0, 64'h0, 1, 1, 0, {4'h0, ID1});
        resp(4'h0, ID1);
        resp(4'h1, ID1);
        idle(1);

        // simultaneous accept/retire at outstanding 3, then reset at 5
        for (int i = 0; i < 3; i++) step(0, 1, 64'(500 + i), 1, 0, 0, 6'h0);
        step(0, 1, 64'h5A5, 1, 1, 1, {4'h1, ID1});
        idle(1);
        step(0, 1, 64'h600, 1, 0, 0, 6'h0);
        step(0, 1, 64'h601, 1, 0, 0, 6'h0);
        do_reset(1);
        resp(4'h2, ID1);
        idle(1);

        // randomized traffic with phases of varying response pressure
        for (int c = 0; c < 3000; c++) begin
            int unsigned bvp;
            logic [3:0]  s;
            logic [1:0]  id;
            bit          rst;
            bvp = (c / 150) % 3 == 0 ? 10 : ((c / 150) % 3 == 1 ? 50 : 90);
            if (live.size() != 0 && $urandom_range(3) != 0) s = 4'(live[0]);
            else                                             s = 4'($urandom);
            id  = ($urandom_range(4) == 0) ? (ID1 ^ 2'($urandom_range(3, 1))) : ID1;
            rst = ($urandom_range(399) == 0);
            step(rst, $urandom_range(99) < 70, {$urandom, $urandom},
                 $urandom_range(99) < 70, $urandom_range(99) < bvp,
                 $urandom_range(99) < 85, {s, id});
        end
        idle(1);

        // wrap-around on the 2-bit sequence instance
        @(negedge clk); d2_reset = 1;
        @(negedge clk); d2_reset = 0;
        for (int i = 0; i < 10; i++) begin
            logic [1:0] t;
            t = 2'(i % 4);
            @(negedge clk);
            d2_s_awvalid = 1; d2_s_awpayload = 8'(i); d2_m_awready = 1; d2_bvalid = 0;
            #1 check("d2_s_awready", d2_s_awready, 1'b1);
            @(posedge clk); #1;
            check("d2_m_awvalid", d2_m_awvalid, 1'b1);
            check("d2_m_awid", d2_m_awid, {t, ID2});
            check("d2_outstanding_acc", d2_outstanding, 3'd1);
            @(negedge clk);
            d2_s_awvalid = 0; d2_bvalid = 1; d2_bready = 1; d2_bid = {t, ID2};
            @(posedge clk); #1;
            check("d2_seq_err", d2_seq_err, 1'b0);
            check("d2_outstanding_ret", d2_outstanding, 3'd0);
            check("d2_empty", d2_empty, 1'b1);
        end
        @(negedge clk); d2_bvalid = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
